// File: rtl/glb_sink_pkg.sv
// Shared types and constants for the GLB stream sink and its backpressure generator.
// Holds the FSM state encoding, backpressure mode codes and the LFSR step function.
package glb_sink_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_FLUSH,
      ARM,
      HDR,
      PAY,
      NEXT,
      DONE
   } sink_state_t;

   localparam int BP_ALWAYS = 0;
   localparam int BP_LFSR   = 1;
   localparam int BP_DUTY   = 2;

   // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/glb_sink_bp_gen.sv
// Ready-enable generator: always-on, LFSR-random or fixed DUTY_ON:1 pattern.
// Latency: en is combinational and is registered by the parent; no backpressure of its own.
module glb_sink_bp_gen
   import glb_sink_pkg::*;
#(
   parameter int          BP_MODE = 1,
   parameter logic [15:0] BP_SEED = 16'hACE1,
   parameter int          DUTY_ON = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic step,
   input  logic restart,
   output logic en
);

   localparam int CW = $clog2(DUTY_ON + 1);

   logic [15:0]   lfsr_q;
   logic [15:0]   lfsr_d;
   logic [CW-1:0] duty_q;
   logic [CW-1:0] duty_d;

   always_comb begin
      lfsr_d = lfsr_q;
      duty_d = duty_q;
      en     = 1'b1;

      if (step) begin
         lfsr_d = lfsr_step(lfsr_q);
      end

      // Restart consumes pattern slot 0, so the count resumes at 1.
      if (restart) begin
         duty_d = CW'(1);
      end else if (step) begin
         duty_d = (duty_q >= CW'(DUTY_ON)) ? '0 : duty_q + 1'b1;
      end

      case (BP_MODE)
         BP_LFSR: en = lfsr_q[0];
         BP_DUTY: en = restart || (duty_q < CW'(DUTY_ON));
         default: en = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= BP_SEED;
         duty_q <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         duty_q <= duty_d;
      end
   end

endmodule

// File: rtl/glb_stream_sink.sv
// GLB read-side sink: captures NUM_BLOCKS length-prefixed blocks per flush into local RAM.
// Latency: ready is registered, readback data 1 cycle, sizes combinational; backpressure per BP_MODE.
module glb_stream_sink
   import glb_sink_pkg::*;
#(
   parameter int          DATA_WIDTH = 16,
   parameter int          DEPTH      = 2048,
   parameter int          NUM_BLOCKS = 2,
   parameter int          BP_MODE    = 1,
   parameter logic [15:0] BP_SEED    = 16'hACE1,
   parameter int          DUTY_ON    = 3,
   localparam int         AW         = $clog2(DEPTH),
   localparam int         BW         = ($clog2(NUM_BLOCKS) > 0) ? $clog2(NUM_BLOCKS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [DATA_WIDTH:0]   data,
   input  logic                  valid,
   output logic                  ready,
   output logic                  done,
   output logic                  err,
   input  logic [BW-1:0]         rd_blk,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [15:0]           rd_size
);

   localparam logic [DATA_WIDTH:0] DEPTH_W = (DATA_WIDTH + 1)'(DEPTH);

   sink_state_t           state_q, state_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [BW-1:0]         blk_q, blk_d;
   logic [DATA_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0] len_q, len_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [15:0]           size_q [NUM_BLOCKS];
   logic [15:0]           size_d [NUM_BLOCKS];
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   logic [DATA_WIDTH-1:0] mem [NUM_BLOCKS][DEPTH];
   logic                  mem_we;

   logic                  xfer;
   logic [DATA_WIDTH-1:0] hdr_len;
   logic                  hdr_over;
   logic [DATA_WIDTH-1:0] idx_inc;
   logic                  bp_step;
   logic                  bp_restart;
   logic                  bp_en;
   logic                  unused_data_msb;

   assign xfer            = ready_q && valid;
   assign hdr_len         = data[DATA_WIDTH-1:0];
   assign hdr_over        = {1'b0, hdr_len} > DEPTH_W;
   assign idx_inc         = idx_q + 1'b1;
   assign unused_data_msb = data[DATA_WIDTH];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      idx_d   = idx_q;
      len_d   = len_q;
      err_d   = err_q;
      size_d  = size_q;
      mem_we  = 1'b0;

      // Flush outranks everything, including a word handshaking this cycle.
      if (flush) begin
         state_d = WAIT_FLUSH;
         cnt_d   = '0;
         blk_d   = '0;
         idx_d   = '0;
         err_d   = 1'b0;
         for (int b = 0; b < NUM_BLOCKS; b++) begin
            size_d[b] = '0;
         end
      end else begin
         unique case (state_q)
            IDLE, DONE: ;
            WAIT_FLUSH: begin
               state_d = ARM;
               cnt_d   = '0;
            end
            ARM: begin
               if (cnt_q == 2'd2) begin
                  state_d = HDR;
                  blk_d   = '0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            HDR: begin
               if (xfer) begin
                  size_d[blk_q] = hdr_over ? 16'(DEPTH) : 16'(hdr_len);
                  if (hdr_over) begin
                     err_d = 1'b1;
                  end
                  len_d   = hdr_len;
                  idx_d   = '0;
                  state_d = (hdr_len != '0) ? PAY : NEXT;
               end
            end
            PAY: begin
               if (xfer) begin
                  // Words past DEPTH are still consumed so the stream stays aligned.
                  mem_we = {1'b0, idx_q} < DEPTH_W;
                  idx_d  = idx_inc;
                  if (idx_inc == len_q) begin
                     state_d = NEXT;
                  end
               end
            end
            NEXT: begin
               if (blk_q == BW'(NUM_BLOCKS - 1)) begin
                  state_d = DONE;
               end else begin
                  blk_d   = blk_q + 1'b1;
                  state_d = HDR;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bp_step    = (state_d == HDR) || (state_d == PAY);
   assign bp_restart = (state_d == HDR) && (state_q != HDR);
   assign ready_d    = bp_step && bp_en;
   assign done_d     = (state_d == DONE);

   glb_sink_bp_gen #(
      .BP_MODE (BP_MODE),
      .BP_SEED (BP_SEED),
      .DUTY_ON (DUTY_ON)
   ) u_bp_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (bp_step),
      .restart (bp_restart),
      .en      (bp_en)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         blk_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int b = 0; b < NUM_BLOCKS; b++) begin
            size_q[b] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         err_q   <= err_d;
         size_q  <= size_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[blk_q][idx_q[AW-1:0]] <= data[DATA_WIDTH-1:0];
      end
   end

   // Registered read of the pre-write array contents gives read-old-data on collisions.
   always_comb begin
      rd_data_d = '0;
      if (int'(rd_blk) < NUM_BLOCKS) begin
         rd_data_d = mem[rd_blk][rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign ready   = ready_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rd_data = rd_data_q;
   assign rd_size = (int'(rd_blk) < NUM_BLOCKS) ? size_q[rd_blk] : 16'h0000;

endmodule

// File: tb/tb_glb_stream_sink.sv
// Bench for glb_stream_sink: three instances (always-ready, LFSR, duty-cycle) share one stimulus path.
module tb_glb_stream_sink;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        flush;
   logic        valid;
   logic [16:0] data;
   logic [0:0]  rd_blk;
   logic [6:0]  rd_addr;
   int          sel;

   logic [2:0]  rdy_v;
   logic [2:0]  done_v;
   logic [2:0]  err_v;
   logic [15:0] rdd_v [3];
   logic [15:0] rsz_v [3];

   int tests = 0;
   int fails = 0;
   int cyc_cnt;
   int lo_cnt;

   typedef struct {
      int          blk;
      int          addr;
      logic [15:0] dat;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int          blk;
      int          addr;
      logic [15:0] exp_dat;
      logic [15:0] exp_size;
   } vec_t;
   vec_t t1_tab [6];

   glb_stream_sink #(.DATA_WIDTH(16), .DEPTH(16), .NUM_BLOCKS(1), .BP_MODE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(flush && (sel == 0)), .data(data),
      .valid(valid && (sel == 0)), .ready(rdy_v[0]), .done(done_v[0]), .err(err_v[0]),
      .rd_blk(rd_blk), .rd_addr(rd_addr[3:0]), .rd_data(rdd_v[0]), .rd_size(rsz_v[0]));

   glb_stream_sink #(.DATA_WIDTH(16), .DEPTH(128), .NUM_BLOCKS(2), .BP_MODE(1), .BP_SEED(16'hACE1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(flush && (sel == 1)), .data(data),
      .valid(valid && (sel == 1)), .ready(rdy_v[1]), .done(done_v[1]), .err(err_v[1]),
      .rd_blk(rd_blk), .rd_addr(rd_addr[6:0]), .rd_data(rdd_v[1]), .rd_size(rsz_v[1]));

   glb_stream_sink #(.DATA_WIDTH(16), .DEPTH(8), .NUM_BLOCKS(2), .BP_MODE(2), .DUTY_ON(3)) u_c (
      .clk(clk), .rst_n(rst_n), .flush(flush && (sel == 2)), .data(data),
      .valid(valid && (sel == 2)), .ready(rdy_v[2]), .done(done_v[2]), .err(err_v[2]),
      .rd_blk(rd_blk), .rd_addr(rd_addr[2:0]), .rd_data(rdd_v[2]), .rd_size(rsz_v[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds one word on the bus until the selected sink accepts it.
   task automatic send(input logic [16:0] w);
      int n = 0;
      data  = w;
      valid = 1'b1;
      while (!rdy_v[sel] && n < 200) begin
         tick();
         n++;
         cyc_cnt++;
         lo_cnt++;
      end
      if (n >= 200) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: ready still 0 after %0d cycles, expected 1", n);
      end else begin
         tick();
         cyc_cnt++;
      end
      valid = 1'b0;
   endtask

   task automatic send_block(input int blk, input int len, input int base, input int depth);
      sb_t e;
      send(17'(len));
      for (int i = 0; i < len; i++) begin
         send(17'(base + i));
         if (i < depth) begin
            e.blk = blk;
            e.addr = i;
            e.dat = 16'(base + i);
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic flush_and_arm();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (4) tick();
   endtask

   task automatic drain(input string name);
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         rd_blk  = e.blk[0:0];
         rd_addr = 7'(e.addr);
         tick();
         chk(name, rdd_v[sel], e.dat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ready_seen;

      t1_tab[0] = '{0, 0, 16'h0011, 16'd4};
      t1_tab[1] = '{0, 1, 16'h0022, 16'd4};
      t1_tab[2] = '{0, 2, 16'h0033, 16'd4};
      t1_tab[3] = '{0, 3, 16'h0044, 16'd4};
      t1_tab[4] = '{1, 0, 16'h0000, 16'd0};
      t1_tab[5] = '{1, 5, 16'h0000, 16'd0};

      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; data = '0;
      rd_blk = '0; rd_addr = '0; sel = 0;
      repeat (3) tick();
      for (int s = 0; s < 3; s++) begin
         chk("rst_ready", rdy_v[s], 0);
         chk("rst_done", done_v[s], 0);
         chk("rst_err", err_v[s], 0);
         chk("rst_rd_data", rdd_v[s], 0);
         chk("rst_rd_size", rsz_v[s], 0);
      end
      rst_n = 1'b1;
      tick();

      // T1: always-ready, single block; MSB of the third word must be ignored.
      sel = 0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t1_ready_rise", rdy_v[0], (i == 4));
      end
      send(17'h4);
      send(17'h11); send(17'h22); send(17'h10033); send(17'h44);
      chk("t1_done_early", done_v[0], 0);
      tick();
      chk("t1_done", done_v[0], 1);
      chk("t1_ready_in_done", rdy_v[0], 0);
      for (int i = 0; i < 6; i++) begin
         rd_blk  = t1_tab[i].blk[0:0];
         rd_addr = 7'(t1_tab[i].addr);
         #1;
         chk("t1_rd_size", rsz_v[0], t1_tab[i].exp_size);
         tick();
         chk("t1_rd_data", rdd_v[0], t1_tab[i].exp_dat);
      end

      // Flush coinciding with a handshake drops the word; old RAM contents survive.
      flush_and_arm();
      send(17'h6); send(17'hAA); send(17'hBB);
      chk("t1b_pre_ready", rdy_v[0], 1);
      data = 17'hCC; valid = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; valid = 1'b0;
      chk("t1b_flush_ready", rdy_v[0], 0);
      repeat (4) tick();
      send(17'h1); send(17'hDD);
      tick();
      chk("t1b_done", done_v[0], 1);
      rd_blk = 1'b0; #1;
      chk("t1b_size", rsz_v[0], 1);
      rd_addr = 7'd0; tick(); chk("t1b_rd0", rdd_v[0], 16'hDD);
      rd_addr = 7'd1; tick(); chk("t1b_rd1", rdd_v[0], 16'hBB);
      rd_addr = 7'd2; tick(); chk("t1b_rd2", rdd_v[0], 16'h33);

      // T2: LFSR backpressure, two ramp blocks with valid held high.
      sel = 1;
      flush_and_arm();
      cyc_cnt = 0; lo_cnt = 0;
      send_block(0, 100, 16'h0100, 128);
      send_block(1, 37, 16'h4000, 128);
      chk("t2_done_early", done_v[1], 0);
      tick();
      chk("t2_done", done_v[1], 1);
      chk("t2_err", err_v[1], 0);
      chk("t2_backpressure", (lo_cnt * 4 >= cyc_cnt), 1);
      rd_blk = 1'b0; #1; chk("t2_size0", rsz_v[1], 100);
      rd_blk = 1'b1; #1; chk("t2_size1", rsz_v[1], 37);
      drain("t2_rd_data");

      // T3: oversize header on DEPTH=8 with 3:1 duty backpressure.
      sel = 2;
      flush_and_arm();
      cyc_cnt = 0; lo_cnt = 0;
      send(17'd10);
      chk("t3_err", err_v[2], 1);
      for (int i = 0; i < 10; i++) begin
         sb_t e;
         send(17'(i));
         if (i < 8) begin
            e.blk = 0; e.addr = i; e.dat = 16'(i);
            sb_q.push_back(e);
         end
         if (i == 8) chk("t3_done_before_last", done_v[2], 0);
      end
      chk("t3_duty_cycles", cyc_cnt, 14);
      chk("t3_duty_lows", lo_cnt, 3);
      chk("t3_done_after_blk0", done_v[2], 0);
      send_block(1, 1, 16'h55, 8);
      tick();
      chk("t3_done", done_v[2], 1);
      chk("t3_err_sticky", err_v[2], 1);
      rd_blk = 1'b0; #1; chk("t3_size0", rsz_v[2], 8);
      rd_blk = 1'b1; #1; chk("t3_size1", rsz_v[2], 1);
      drain("t3_rd_data");

      // T4: empty first block goes straight to the bubble.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_flush_done", done_v[2], 0);
      chk("t4_flush_err", err_v[2], 0);
      repeat (3) tick();
      send(17'd0);
      chk("t4_no_pay", rdy_v[2], 0);
      send_block(1, 2, 16'hA, 8);
      tick();
      chk("t4_done", done_v[2], 1);
      rd_blk = 1'b0; #1; chk("t4_size0", rsz_v[2], 0);
      rd_blk = 1'b1; #1; chk("t4_size1", rsz_v[2], 2);
      drain("t4_rd_data");

      // T5: abort after 5 of 20 payload words, then a clean transfer (second header == DEPTH).
      flush_and_arm();
      send(17'd20);
      for (int i = 0; i < 5; i++) send(17'(16'h60 + i));
      chk("t5_err_pre", err_v[2], 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_done", done_v[2], 0);
      chk("t5_err", err_v[2], 0);
      rd_blk = 1'b0; #1; chk("t5_size0_clr", rsz_v[2], 0);
      rd_blk = 1'b1; #1; chk("t5_size1_clr", rsz_v[2], 0);
      repeat (3) tick();
      send_block(0, 3, 16'h70, 8);
      send_block(1, 8, 16'h80, 8);
      tick();
      chk("t5_done2", done_v[2], 1);
      chk("t5_err2", err_v[2], 0);
      rd_blk = 1'b0; #1; chk("t5_size0", rsz_v[2], 3);
      rd_blk = 1'b1; #1; chk("t5_size1", rsz_v[2], 8);
      drain("t5_rd_data");

      // T6: asynchronous reset in the middle of a payload.
      flush_and_arm();
      send(17'd4); send(17'd1); send(17'd2); send(17'd3);
      chk("t6_pre_ready", rdy_v[2], 1);
      rst_n = 1'b0;
      #1;
      chk("t6_ready_async", rdy_v[2], 0);
      chk("t6_done_async", done_v[2], 0);
      rd_blk = 1'b0; #1;
      chk("t6_size_async", rsz_v[2], 0);
      #2;
      rst_n = 1'b1;
      ready_seen = 0;
      valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rdy_v[2]) ready_seen++;
      end
      valid = 1'b0;
      chk("t6_idle_holds", ready_seen, 0);
      flush_and_arm();
      send_block(0, 0, 0, 8);
      send_block(1, 1, 16'h99, 8);
      tick();
      chk("t6_rearm_done", done_v[2], 1);
      drain("t6_rd_data");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
